uart_operand_loader: RTL and testbench
======================================

// Module: uart_operand_loader
// PURPOSE
//  Packs UART receive bytes into WORD_W-bit words and streams them to operand memory.
//  Operands arrive in fixed order (op 0 = m, 1 = p, 2 = q, 3 = e), each WORDS_PER_OP words.
//  Sits between uart_rx and the RSA operand RAMs.
//  Adds over the inline packer: parametrised width/count/endianness, write backpressure,
//  inter-byte timeout resync, per-operand done flags and restart control.
// PARAMETERS
//  WORD_W        32  word width; multiple of 8; BPW = WORD_W/8 bytes per word
//  NUM_OPS       4   number of operands loaded in sequence
//  WORDS_PER_OP  32  words per operand
//  BIG_ENDIAN    1   1: first byte -> word[WORD_W-1 -:8]; 0: first byte -> word[7:0]
//  TIMEOUT_CYC   0   idle clk cycles with partial word before resync; 0 disables
//  Derived: OPW = max(1,clog2(NUM_OPS)), AW = max(1,clog2(WORDS_PER_OP))
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  reset       in   1        asynchronous, active-low reset
//  rx_valid    in   1        one-cycle strobe per received byte
//  rx_byte     in   8        received byte, valid with rx_valid
//  start       in   1        pulse: clear all state and arm a new load
//  wr_en       out  1        write request, held until accepted
//  wr_ready    in   1        memory accepts when wr_en && wr_ready
//  wr_op       out  OPW      operand select for pending write
//  wr_addr     out  AW       word index within operand
//  wr_data     out  WORD_W   assembled word
//  busy        out  1        state is LOAD or FLUSH
//  op_done     out  NUM_OPS  sticky; bit k set when last word of op k is accepted
//  load_done   out  1        sticky; all operands written
//  overrun     out  1        sticky; word completed while a write was still pending
//  timeout_err out  1        sticky; partial word discarded by timeout
// BEHAVIOUR
//  Reset (reset=0): state IDLE; every output 0; byte/word/op counters 0; shift reg 0.
//  FSM: IDLE -start-> LOAD; LOAD -last word latched-> FLUSH;
//       FLUSH -write accepted-> DONE; DONE -start-> LOAD.
//  In IDLE and DONE, rx_valid is ignored.
//  start (any state) wins over all events in the same cycle:
//   - counters, op_done, load_done, overrun, timeout_err and wr_en cleared;
//   - partial word discarded; next state LOAD.
//  LOAD, byte collection: each rx_valid shifts rx_byte into the word per BIG_ENDIAN; byte_cnt++.
//  Word complete on the BPW-th byte, with wr_en low or accepted in that same cycle:
//   - next cycle wr_en=1; wr_data/wr_op/wr_addr = word, op_idx, word_idx;
//   - byte_cnt -> 0; word_idx++.
//   - word_idx wraps at WORDS_PER_OP-1 -> 0 and op_idx++.
//   - on op NUM_OPS-1, word WORDS_PER_OP-1: go to FLUSH; no further bytes accepted.
//   - Latency: last byte strobe -> wr_en high = 1 cycle.
//  Word complete while wr_en=1 and wr_ready=0:
//   - overrun=1; word dropped; counters not advanced; byte_cnt -> 0.
//  Write handshake:
//   - wr_en, wr_op, wr_addr and wr_data stable until the cycle wr_en && wr_ready is sampled;
//   - wr_en drops the next cycle unless a new word loads in that same cycle.
//   - op_done[wr_op] set on acceptance of address WORDS_PER_OP-1.
//  FLUSH: waits for acceptance -> DONE, load_done=1, busy=0.
//  Timeout (TIMEOUT_CYC>0): gap counter clears on rx_valid, counts while 0 < byte_cnt < BPW.
//   - Reaching TIMEOUT_CYC: byte_cnt -> 0, partial discarded, timeout_err=1.
//   - Word/op counters are not changed.
//  Async reset mid-load: immediate return to reset values; wr_en drops with no handshake.
// TESTING  (WORD_W=32, NUM_OPS=4, WORDS_PER_OP=2, TIMEOUT_CYC=16, wr_ready=1 unless stated)
//  1. start; bytes 11,22,33,44 -> one cycle later wr_en=1, op 0, addr 0, data 0x11223344.
//     Repeat with BIG_ENDIAN=0 -> data 0x44332211.
//  2. start; 32 bytes 00..1F -> 8 writes, op 0..3 x addr 0..1.
//     op_done bits set in order 0001,0011,0111,1111; load_done=1; busy=0.
//     Extra bytes after DONE -> no wr_en.
//  3. wr_ready=0 after first word; send 4 more bytes -> overrun=1; first word held unchanged.
//     Raise wr_ready -> accepted, addr 0; the next word written goes to addr 1.
//  4. Send AA,BB; wait 16 idle cycles -> timeout_err=1.
//     Then send 01,02,03,04 -> data 0x01020304, addr 0.
//  5. Assert start after 3 bytes of op 1 -> counters and flags cleared.
//     Next 4 bytes -> op 0, addr 0.
//  6. Drop reset mid-FLUSH with wr_en=1 -> wr_en, busy, op_done and load_done all 0 immediately.
//     Bytes ignored until start.

Source files
------------

// File: rtl/uart_operand_loader.sv
// Packs UART receive bytes into WORD_W-bit words and streams them, operand by operand,
// to operand memory with a held write request, timeout resync and sticky status flags.
module uart_operand_loader #(
  parameter  int WORD_W       = 32,
  parameter  int NUM_OPS      = 4,
  parameter  int WORDS_PER_OP = 32,
  parameter  int BIG_ENDIAN   = 1,
  parameter  int TIMEOUT_CYC  = 0,
  localparam int OPW          = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
  localparam int AW           = (WORDS_PER_OP > 1) ? $clog2(WORDS_PER_OP) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              start,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [OPW-1:0]    wr_op,
  output logic [AW-1:0]     wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic [NUM_OPS-1:0] op_done,
  output logic              load_done,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int BPW    = WORD_W / 8;
  localparam int BCW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int GW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  localparam logic [BCW-1:0] BC_LAST  = BCW'(BPW - 1);
  localparam logic [AW-1:0]  W_LAST   = AW'(WORDS_PER_OP - 1);
  localparam logic [OPW-1:0] OP_LAST  = OPW'(NUM_OPS - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(TO_LAST);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]    shift_q, shift_d;
  logic [AW-1:0]        word_idx_q, word_idx_d;
  logic [OPW-1:0]       op_idx_q, op_idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 wr_en_q, wr_en_d;
  logic [OPW-1:0]       wr_op_q, wr_op_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]    wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic [NUM_OPS-1:0]   op_done_q, op_done_d;
  logic                 load_done_q, load_done_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [WORD_W-1:0]    byte_lo, byte_hi, assembled;
  logic                 accept;

  always_comb begin
    byte_lo = '0;
    byte_lo[7:0] = rx_byte;
    byte_hi = '0;
    byte_hi[WORD_W-1 -: 8] = rx_byte;
    if (BIG_ENDIAN != 0) assembled = (shift_q << 8) | byte_lo;
    else                 assembled = (shift_q >> 8) | byte_hi;
  end

  assign accept = wr_en_q && wr_ready;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    word_idx_d    = word_idx_q;
    op_idx_d      = op_idx_q;
    gap_d         = gap_q;
    wr_en_d       = wr_en_q;
    wr_op_d       = wr_op_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    op_done_d     = op_done_q;
    load_done_d   = load_done_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;

    if (accept) begin
      wr_en_d = 1'b0;
      if (wr_addr_q == W_LAST) op_done_d[wr_op_q] = 1'b1;
      if (state_q == S_FLUSH) begin
        state_d     = S_DONE;
        load_done_d = 1'b1;
      end
    end

    if (state_q == S_LOAD) begin
      if (rx_valid) begin
        gap_d = '0;
        if (byte_cnt_q == BC_LAST) begin
          byte_cnt_d = '0;
          shift_d    = '0;
          // A new word may reload the write port in the same cycle the old one is accepted.
          if (!wr_en_q || wr_ready) begin
            wr_en_d   = 1'b1;
            wr_data_d = assembled;
            wr_op_d   = op_idx_q;
            wr_addr_d = word_idx_q;
            if (word_idx_q == W_LAST) begin
              word_idx_d = '0;
              if (op_idx_q == OP_LAST) state_d = S_FLUSH;
              else                     op_idx_d = op_idx_q + 1'b1;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
            end
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          shift_d    = assembled;
        end
      end else if ((TIMEOUT_CYC > 0) && (byte_cnt_q != '0)) begin
        if (gap_q == GAP_LAST) begin
          gap_d         = '0;
          byte_cnt_d    = '0;
          shift_d       = '0;
          timeout_err_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    end

    if (start) begin
      state_d       = S_LOAD;
      byte_cnt_d    = '0;
      shift_d       = '0;
      word_idx_d    = '0;
      op_idx_d      = '0;
      gap_d         = '0;
      wr_en_d       = 1'b0;
      wr_op_d       = '0;
      wr_addr_d     = '0;
      wr_data_d     = '0;
      op_done_d     = '0;
      load_done_d   = 1'b0;
      overrun_d     = 1'b0;
      timeout_err_d = 1'b0;
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      word_idx_q    <= '0;
      op_idx_q      <= '0;
      gap_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_op_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      op_done_q     <= '0;
      load_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      word_idx_q    <= word_idx_d;
      op_idx_q      <= op_idx_d;
      gap_q         <= gap_d;
      wr_en_q       <= wr_en_d;
      wr_op_q       <= wr_op_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      op_done_q     <= op_done_d;
      load_done_q   <= load_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_op       = wr_op_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign op_done     = op_done_q;
  assign load_done   = load_done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_operand_loader.sv
// Scoreboard bench for uart_operand_loader: big-endian instance fully checked,
// little-endian twin checked for byte order.
module tb_uart_operand_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid, wr_ready;
  logic [7:0]  rx_byte;

  logic        wr_en, busy, load_done, overrun, timeout_err;
  logic [1:0]  wr_op;
  logic [0:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  op_done;

  logic        le_wr_en, le_busy, le_load_done, le_overrun, le_timeout_err;
  logic [1:0]  le_wr_op;
  logic [0:0]  le_wr_addr;
  logic [31:0] le_wr_data;
  logic [3:0]  le_op_done;

  typedef struct {
    logic [1:0]  op;
    logic [0:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  uart_operand_loader #(.WORD_W(32), .NUM_OPS(4), .WORDS_PER_OP(2), .BIG_ENDIAN(1), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .start(start),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .op_done(op_done), .load_done(load_done), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  uart_operand_loader #(.WORD_W(32), .NUM_OPS(4), .WORDS_PER_OP(2), .BIG_ENDIAN(0), .TIMEOUT_CYC(16)) dut_le (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .start(start),
    .wr_en(le_wr_en), .wr_ready(wr_ready), .wr_op(le_wr_op), .wr_addr(le_wr_addr),
    .wr_data(le_wr_data), .busy(le_busy), .op_done(le_op_done), .load_done(le_load_done),
    .overrun(le_overrun), .timeout_err(le_timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Accepted writes are sampled on the falling edge, before the accepting rising edge.
  always @(negedge clk) begin
    if (reset && wr_en && wr_ready) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_op",   64'(wr_op),   64'(e.op));
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    cyc(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit push, input int op, input int addr);
    wr_t e;
    if (push) begin
      e.op   = 2'(op);
      e.addr = 1'(addr);
      e.data = w;
      sb.push_back(e);
    end
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) cyc(1);
    chk("drain_pending", 64'(sb.size()), 64'd0);
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_byte = '0; wr_ready = 1'b1;
    #12;
    chk("reset_flags", 64'({wr_en, busy, load_done, overrun, timeout_err, op_done}), 64'd0);
    chk("reset_data", 64'(wr_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1);

    // 1: byte order and one-cycle latency
    pulse_start();
    send_word(32'h11223344, 1'b1, 0, 0);
    chk("latency_wr_en", 64'(wr_en), 64'd1);
    chk("be_data", 64'(wr_data), 64'h11223344);
    chk("le_data", 64'(le_wr_data), 64'h44332211);
    drain();

    // 2: full load of 8 words, sticky per-operand done flags
    pulse_start();
    chk("busy_load", 64'(busy), 64'd1);
    for (int k = 0; k < 8; k++) begin
      w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      send_word(w, 1'b1, k / 2, k % 2);
      cyc(1);
      chk("op_done_seq", 64'(op_done), 64'((1 << ((k + 1) / 2)) - 1));
    end
    chk("load_done", 64'(load_done), 64'd1);
    chk("busy_done", 64'(busy), 64'd0);
    send_word(32'hDEADBEEF, 1'b0, 0, 0);
    cyc(3);
    chk("done_no_wr", 64'(wr_en), 64'd0);

    // 3: backpressure and overrun
    pulse_start();
    wr_ready = 1'b0;
    send_word(32'hA1A2A3A4, 1'b1, 0, 0);
    send_word(32'hB1B2B3B4, 1'b0, 0, 0);
    cyc(1);
    chk("overrun", 64'(overrun), 64'd1);
    chk("held_en", 64'(wr_en), 64'd1);
    chk("held_data", 64'(wr_data), 64'hA1A2A3A4);
    chk("held_addr", 64'(wr_addr), 64'd0);
    wr_ready = 1'b1;
    drain();
    send_word(32'hC1C2C3C4, 1'b1, 0, 1);
    drain();

    // 4: inter-byte timeout resync
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    cyc(10);
    chk("timeout_early", 64'(timeout_err), 64'd0);
    cyc(10);
    chk("timeout_err", 64'(timeout_err), 64'd1);
    send_word(32'h01020304, 1'b1, 0, 0);
    drain();

    // 5: start mid-operand clears everything
    pulse_start();
    send_word(32'h10111213, 1'b1, 0, 0);
    send_word(32'h14151617, 1'b1, 0, 1);
    drain();
    chk("op0_done", 64'(op_done), 64'd1);
    send_byte(8'h20); send_byte(8'h21); send_byte(8'h22);
    pulse_start();
    chk("restart_flags", 64'({wr_en, load_done, overrun, timeout_err, op_done}), 64'd0);
    send_word(32'h30313233, 1'b1, 0, 0);
    drain();

    // 6: asynchronous reset while flushing
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      send_word(32'h50000000 + 32'(k), 1'b1, k / 2, k % 2);
      drain();
    end
    wr_ready = 1'b0;
    send_word(32'h5F5F5F5F, 1'b0, 3, 1);
    cyc(1);
    chk("flush_busy", 64'(busy), 64'd1);
    chk("flush_wr_en", 64'(wr_en), 64'd1);
    #3 reset = 1'b0;
    #1;
    chk("async_reset", 64'({wr_en, busy, load_done, op_done}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    wr_ready = 1'b1;
    send_word(32'h77777777, 1'b0, 0, 0);
    cyc(3);
    chk("idle_ignores_rx", 64'({wr_en, busy}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
